// File: rtl/output_limit_arbiter.sv
// Round-robin arbiter moving words from N_CH FWFT channels into one output FIFO, with an optional word-count limit.
// Define OUTPUT_ARB_PKT_LOCK_EN to hold a grant until the pkt_end word; otherwise arbitration is per word.
module output_limit_arbiter #(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 16,
    parameter int LIMIT_W = 16,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [N_CH*WIDTH-1:0]   ch_din,
    input  logic [N_CH-1:0]         ch_pkt_end,
    input  logic [N_CH-1:0]         ch_empty,
    output logic [N_CH-1:0]         ch_rd_en,
    output logic [WIDTH-1:0]        dout,
    output logic                    wr_en,
    input  logic                    full,
    input  logic                    mode_limit,
    input  logic                    reg_output_limit,
    output logic [LIMIT_W-1:0]      output_limit,
    output logic                    output_limit_not_done,
    output logic [CH_W-1:0]         cur_ch,
    output logic                    busy
);

    // Handshake: a channel word is consumed on any cycle its ch_rd_en is high (FWFT head is
    // valid whenever ch_empty is low); wr_en is a one-cycle valid for dout; full is
    // backpressure sampled in the same cycle, relying on the downstream one-word slack.

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]    last_grant_q, last_grant_d;
    logic [LIMIT_W-1:0] cnt_q, cnt_d;
    logic [LIMIT_W-1:0] output_limit_q, output_limit_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               wr_en_q, wr_en_d;

    logic               cnt_sat;
    logic               hold;
    logic               pop;
    logic               any_req;
    logic [CH_W-1:0]    grant_ch;

    assign cnt_sat = &cnt_q;
    assign hold    = mode_limit & cnt_sat;
    assign any_req = |(~ch_empty);
    assign pop     = (state_q == ST_XFER) & ~ch_empty[cur_ch_q] & ~full & ~hold;

    // First non-empty channel after the last grant, wrapping around.
    always_comb begin
        logic found;
        found    = 1'b0;
        grant_ch = last_grant_q;
        for (int i = 1; i <= N_CH; i++) begin
            int idx;
            idx = (int'(last_grant_q) + i) % N_CH;
            if (!found && !ch_empty[idx]) begin
                found    = 1'b1;
                grant_ch = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_ch_d     = cur_ch_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    cur_ch_d     = grant_ch;
                    last_grant_d = grant_ch;
                    state_d      = ST_XFER;
                end
            end
            ST_XFER: begin
`ifdef OUTPUT_ARB_PKT_LOCK_EN
                if (pop && ch_pkt_end[cur_ch_q]) state_d = ST_IDLE;
`else
                if (pop || ch_empty[cur_ch_q]) state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifndef OUTPUT_ARB_PKT_LOCK_EN
    logic unused_pkt_end;
    assign unused_pkt_end = ^ch_pkt_end;
`endif

    always_comb begin
        ch_rd_en           = '0;
        ch_rd_en[cur_ch_q] = pop;
    end

    always_comb begin
        wr_en_d = pop;
        dout_d  = dout_q;
        if (pop) dout_d = ch_din[int'(cur_ch_q)*WIDTH +: WIDTH];
    end

    // A latch pulse restarts the count, already including a word forwarded on the same edge.
    always_comb begin
        cnt_d          = cnt_q;
        output_limit_d = output_limit_q;
        if (!mode_limit) begin
            cnt_d = '0;
        end else if (reg_output_limit) begin
            output_limit_d = cnt_q;
            cnt_d          = pop ? LIMIT_W'(1) : '0;
        end else if (pop) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= ST_IDLE;
            cur_ch_q       <= '0;
            last_grant_q   <= CH_W'(N_CH - 1);
            cnt_q          <= '0;
            output_limit_q <= '0;
            dout_q         <= '0;
            wr_en_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_ch_q       <= cur_ch_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            output_limit_q <= output_limit_d;
            dout_q         <= dout_d;
            wr_en_q        <= wr_en_d;
        end
    end

    assign dout                  = dout_q;
    assign wr_en                 = wr_en_q;
    assign output_limit          = output_limit_q;
    assign output_limit_not_done = mode_limit & cnt_sat;
    assign cur_ch                = cur_ch_q;
    assign busy                  = (state_q == ST_XFER);

endmodule

// File: doc/output_limit_arbiter.md
OUTPUT_LIMIT_ARBITER -- requirements
Module: output_limit_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of application output channels (2..8).
REQ-002 Parameter WIDTH, default 16, data word width in bits.
REQ-003 Parameter LIMIT_W, default 16, width of word counter and output_limit.
REQ-004 CLK  input  1  sole clock; all logic SHALL be rising-edge on CLK.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 ch_din  input  N_CH*WIDTH  per-channel head word, first-word-fall-through, channel k at bits [k*WIDTH +: WIDTH].
REQ-007 ch_pkt_end  input  N_CH  head word of channel k is last word of its packet.
REQ-008 ch_empty  input  N_CH  channel k has no word.
REQ-009 ch_rd_en  output  N_CH  pop strobe per channel.
REQ-010 dout  output  WIDTH  word toward output FIFO.
REQ-011 wr_en  output  1  dout valid strobe.
REQ-012 full  input  1  downstream almost-full, guaranteeing >=1 word slack.
REQ-013 mode_limit  input  1  output-limit mode enable.
REQ-014 reg_output_limit  input  1  single-cycle pulse, latch word count.
REQ-015 output_limit  output  LIMIT_W  words released at last reg_output_limit.
REQ-016 output_limit_not_done  output  1  counter saturated; more words pending beyond output_limit.
REQ-017 cur_ch  output  clog2(N_CH)  currently granted channel; busy  output  1  FSM in XFER.

Function
REQ-018 FSM SHALL have states IDLE and XFER.
REQ-019 IDLE: if any ch_empty bit is 0, grant first non-empty channel in round-robin order starting at last_grant+1 mod N_CH, update last_grant, go XFER next cycle; else stay.
REQ-020 XFER: ch_rd_en[cur_ch] = !ch_empty[cur_ch] & !full & !hold, combinational; all other ch_rd_en bits 0.
REQ-021 On a cycle with ch_rd_en[cur_ch]=1, next edge SHALL load dout <= head word and assert wr_en for exactly one cycle; latency 1 cycle.
REQ-022 wr_en SHALL be 0 in every cycle not directly following a pop; dout holds its last value.
REQ-023 Popping a word with ch_pkt_end=1 SHALL return FSM to IDLE on the same edge.
REQ-024 Channel empty mid-packet SHALL keep XFER with grant held (no re-arbitration) until pkt_end word is popped.
REQ-025 hold = mode_limit & counter saturated at 2^LIMIT_W-1; forwarding SHALL stall while hold=1.
REQ-026 mode_limit=1: each forwarded word increments counter, saturating; output_limit_not_done = saturated.
REQ-027 reg_output_limit pulse: output_limit <= counter; counter <= 0, or 1 if a word is forwarded on the same edge; saturation clears.
REQ-028 mode_limit=0: counter held at 0, output_limit keeps its value, output_limit_not_done=0, hold=0.
REQ-029 mode_limit 1->0 with counter nonzero SHALL discard the count.

Reset
REQ-030 RESET_N low SHALL immediately force: state IDLE, last_grant N_CH-1 (channel 0 first), counter 0, output_limit 0, dout 0, wr_en 0, output_limit_not_done 0, cur_ch 0, busy 0, ch_rd_en all 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; after release arbitration restarts from channel 0.

Configuration
REQ-032 Macro OUTPUT_ARB_PKT_LOCK_EN defined: packet locking per REQ-023/024.
REQ-033 Macro undefined: ch_pkt_end ignored; FSM SHALL return to IDLE after every popped word (per-word round robin); XFER with empty channel returns to IDLE.

Verification
REQ-034 Reset; ch0 and ch2 each hold 3-word packets (pkt_end on word 3), full=0 -> wr_en 6 cycles: ch0 words then ch2 words, cur_ch 0 then 2.
REQ-035 Lock enabled; ch1 packet of 4 words, ch1 empty after word 2 for 5 cycles, ch3 non-empty -> no ch3 word before ch1 word 4.
REQ-036 full=1 for 10 cycles mid-packet -> ch_rd_en=0, wr_en=0 during those cycles; no word lost or duplicated.
REQ-037 LIMIT_W=4, mode_limit=1, 20 words queued -> exactly 15 forwarded, output_limit_not_done=1; reg_output_limit -> output_limit=15, forwarding resumes.
REQ-038 mode_limit=1, reg_output_limit coincident with 7th forwarded word -> output_limit=6, next pulse after 3 more words -> 4.
REQ-039 RESET_N low mid-packet on ch1 -> all outputs zero within same cycle; after release ch0 served first.
